g3f_step_gen: RTL and testbench

Programmable step-clock generator with soft-start ramp, sitting directly upstream of the three-phase ring generator. Produces the one-cycle SE pulse train that advances the ring, and ramps the pulse period linearly from a start period to a target period (accelerate), holds it (run), and ramps back out (decelerate) before stopping. Phase outputs of the ring only move when SE pulses, so a clean stop leaves them frozen in a valid state.

---
 rtl/g3f_pkg.sv | 17 +
 rtl/g3f_per_cnt.sv | 40 ++++
 rtl/g3f_step_gen.sv | 139 +++++++++++++
 tb/tb_g3f_step_gen.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/g3f_pkg.sv
// g3f_pkg: shared types and constants for the g3f step-clock generator.
//   g3f_state_e : ramp state machine encoding
//   MIN_PER     : shortest legal SE period, so SE always has a low cycle
//   DIV_W_DEF   : default width of period values and the period counter
package g3f_pkg;

   localparam int DIV_W_DEF = 16;
   localparam int MIN_PER   = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCEL = 2'd1,
      RUN   = 2'd2,
      DECEL = 2'd3
   } g3f_state_e;

endpackage

// File: rtl/g3f_per_cnt.sv
// g3f_per_cnt: loadable period down-counter with terminal-count flag.
//   clk_i      : system clock
//   rst_n_i    : async active-low reset, counter clears to 0
//   load_i     : load load_val_i this cycle (wins over decrement)
//   load_val_i : reload value
//   dec_i      : decrement enable, stops at 0
//   tc_o       : high while the count is 1 (the step-event cycle)
module g3f_per_cnt
   import g3f_pkg::*;
#(
   parameter int DIV_W = DIV_W_DEF
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             load_i,
   input  logic [DIV_W-1:0] load_val_i,
   input  logic             dec_i,
   output logic             tc_o
);

   logic [DIV_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i)
         cnt_d = load_val_i;
      else if (dec_i && (cnt_q != '0))
         cnt_d = cnt_q - DIV_W'(1);
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign tc_o = (cnt_q == DIV_W'(1));

endmodule

// File: rtl/g3f_step_gen.sv
// g3f_step_gen: step-clock generator with linear soft-start/soft-stop ramp
// feeding the three-phase ring generator.
//   clk_i       : system clock
//   rst_n_i     : async active-low reset
//   en_i        : run request (level)
//   start_per_i : period at start and end of the ramp
//   target_i    : run period
//   ramp_step_i : period change per SE pulse while ramping
//   se_o        : one-cycle step pulse
//   busy_o      : state is not IDLE
//   at_speed_o  : state is RUN
//   cur_per_o   : period currently in effect
//
// state | meaning
// IDLE  | stopped, no SE, counter held
// ACCEL | ramping CUR_PER toward the target period
// RUN   | CUR_PER equals the target period
// DECEL | ramping CUR_PER back out to the start period, then stop
module g3f_step_gen
   import g3f_pkg::*;
#(
   parameter int DIV_W = DIV_W_DEF
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             en_i,
   input  logic [DIV_W-1:0] start_per_i,
   input  logic [DIV_W-1:0] target_i,
   input  logic [DIV_W-1:0] ramp_step_i,
   output logic             se_o,
   output logic             busy_o,
   output logic             at_speed_o,
   output logic [DIV_W-1:0] cur_per_o
);

   localparam logic [DIV_W-1:0] MIN_PER_W = DIV_W'(MIN_PER);

   g3f_state_e       state_q, state_d;
   logic [DIV_W-1:0] cur_per_q, cur_per_d;
   logic             se_q, se_d;
   logic             busy_q, at_speed_q;

   logic [DIV_W-1:0] st, tgt;
   logic [DIV_W:0]   sum;
   logic [DIV_W-1:0] up_sat, dn_sat, toward_per, decel_per;
   logic             tc, step_evt, cnt_load;

   // Ramp arithmetic, all saturating in DIV_W bits.
   always_comb begin
      st  = (start_per_i < MIN_PER_W) ? MIN_PER_W : start_per_i;
      tgt = (target_i    < MIN_PER_W) ? MIN_PER_W : target_i;
      sum    = {1'b0, cur_per_q} + {1'b0, ramp_step_i};
      up_sat = sum[DIV_W] ? '1 : sum[DIV_W-1:0];
      dn_sat = (cur_per_q > ramp_step_i) ? (cur_per_q - ramp_step_i) : '0;
      // A zero step jumps straight to the destination instead of stalling.
      if ((ramp_step_i == '0) || (cur_per_q == tgt))
         toward_per = tgt;
      else if (cur_per_q > tgt)
         toward_per = (dn_sat < tgt) ? tgt : dn_sat;
      else
         toward_per = (up_sat > tgt) ? tgt : up_sat;
      if (ramp_step_i == '0)
         decel_per = st;
      else
         decel_per = (up_sat > st) ? st : up_sat;
   end

   assign step_evt = tc && (state_q != IDLE);

   always_comb begin
      state_d   = state_q;
      cur_per_d = cur_per_q;
      se_d      = 1'b0;
      cnt_load  = 1'b0;
      case (state_q)
         IDLE: begin
            if (en_i) begin
               state_d   = ACCEL;
               cur_per_d = st;
               cnt_load  = 1'b1;
            end
         end
         default: begin
            // EN is honoured immediately; the running period always completes.
            if (!en_i) begin
               state_d = DECEL;
               if (step_evt) begin
                  se_d      = 1'b1;
                  cnt_load  = 1'b1;
                  cur_per_d = decel_per;
                  if (cur_per_q >= st)
                     state_d = IDLE;
               end
            end else begin
               state_d = (state_q == DECEL) ? ACCEL : state_q;
               if (step_evt) begin
                  se_d      = 1'b1;
                  cnt_load  = 1'b1;
                  cur_per_d = toward_per;
                  state_d   = (toward_per == tgt) ? RUN : ACCEL;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q    <= IDLE;
         cur_per_q  <= '0;
         se_q       <= 1'b0;
         busy_q     <= 1'b0;
         at_speed_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cur_per_q  <= cur_per_d;
         se_q       <= se_d;
         busy_q     <= (state_d != IDLE);
         at_speed_q <= (state_d == RUN);
      end
   end

   g3f_per_cnt #(
      .DIV_W (DIV_W)
   ) u_per_cnt (
      .clk_i      (clk_i),
      .rst_n_i    (rst_n_i),
      .load_i     (cnt_load),
      .load_val_i (cur_per_d),
      .dec_i      (state_q != IDLE),
      .tc_o       (tc)
   );

   assign se_o       = se_q;
   assign busy_o     = busy_q;
   assign at_speed_o = at_speed_q;
   assign cur_per_o  = cur_per_q;

endmodule

// File: tb/tb_g3f_step_gen.sv
module tb_g3f_step_gen;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic [15:0] start_per, target, ramp_step;
   logic        se, busy, at_speed;
   logic [15:0] cur_per;

   always #5 clk = ~clk;

   g3f_step_gen dut (
      .clk_i       (clk),
      .rst_n_i     (rst_n),
      .en_i        (en),
      .start_per_i (start_per),
      .target_i    (target),
      .ramp_step_i (ramp_step),
      .se_o        (se),
      .busy_o      (busy),
      .at_speed_o  (at_speed),
      .cur_per_o   (cur_per)
   );

   typedef struct {
      int ival;
      int cur;
      int at;
      int bsy;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   ref_cyc = 0;
   logic prev_se = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input int ival, input int cur, input int at, input int bsy);
      exp_t e;
      e.ival = ival;
      e.cur  = cur;
      e.at   = at;
      e.bsy  = bsy;
      q.push_back(e);
   endtask

   // Monitor: every SE pulse pops one expected step and checks spacing and outputs.
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_se = 1'b0;
      end else begin
         if (se) begin
            chk("se_back_to_back", int'(prev_se), 0);
            if (q.size() == 0) begin
               chk("unexpected_se", 1, 0);
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("se_spacing", cyc - ref_cyc, e.ival);
               chk("cur_per", int'(cur_per), e.cur);
               chk("at_speed", int'(at_speed), e.at);
               chk("busy", int'(busy), e.bsy);
            end
            ref_cyc = cyc;
         end
         prev_se = se;
      end
   end

   task automatic drain(input string tag);
      int n = 0;
      while (q.size() != 0 && n < 400) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_%s: got %0d pending steps expected 0", tag, q.size());
         q.delete();
      end
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic start_run();
      en      = 1'b1;
      ref_cyc = cyc + 1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n     = 1'b0;
      en        = 1'b0;
      start_per = 16'd20;
      target    = 16'd8;
      ramp_step = 16'd4;
      idle_cycles(3);
      chk("rst_se", int'(se), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_at_speed", int'(at_speed), 0);
      chk("rst_cur_per", int'(cur_per), 0);
      rst_n = 1'b1;
      idle_cycles(5);

      // Ramp up 20 -> 8 in steps of 4, then stop.
      start_run();
      push(20, 16, 0, 1); push(16, 12, 0, 1); push(12, 8, 1, 1);
      push(8, 8, 1, 1);   push(8, 8, 1, 1);
      drain("ramp_up");
      en = 1'b0;
      push(8, 12, 0, 1); push(12, 16, 0, 1); push(16, 20, 0, 1); push(20, 20, 0, 0);
      drain("stop");
      idle_cycles(50);
      chk("stop_busy", int'(busy), 0);
      chk("stop_at_speed", int'(at_speed), 0);

      // Re-enable after two decel pulses.
      start_run();
      push(20, 16, 0, 1); push(16, 12, 0, 1); push(12, 8, 1, 1); push(8, 8, 1, 1);
      drain("ramp_up2");
      en = 1'b0;
      push(8, 12, 0, 1); push(12, 16, 0, 1);
      drain("decel_part");
      en = 1'b1;
      push(16, 12, 0, 1); push(12, 8, 1, 1); push(8, 8, 1, 1);
      drain("reaccel");
      en = 1'b0;
      push(8, 12, 0, 1); push(12, 16, 0, 1); push(16, 20, 0, 1); push(20, 20, 0, 0);
      drain("stop2");
      idle_cycles(50);

      // Clamp: target 0, start 1 both become 2.
      target    = 16'd0;
      start_per = 16'd1;
      ramp_step = 16'd1;
      start_run();
      repeat (6) push(2, 2, 1, 1);
      drain("clamp");
      en = 1'b0;
      push(2, 2, 0, 0);
      drain("clamp_stop");
      idle_cycles(30);
      chk("clamp_busy", int'(busy), 0);

      // Zero ramp step jumps straight to destination periods.
      start_per = 16'd10;
      target    = 16'd4;
      ramp_step = 16'd0;
      start_run();
      push(10, 4, 1, 1); push(4, 4, 1, 1); push(4, 4, 1, 1);
      drain("step0");
      en = 1'b0;
      push(4, 10, 0, 1); push(10, 10, 0, 0);
      drain("step0_stop");
      idle_cycles(30);

      // Reset while an SE pulse is high.
      start_per = 16'd20;
      target    = 16'd8;
      ramp_step = 16'd4;
      start_run();
      push(20, 16, 0, 1); push(16, 12, 0, 1);
      drain("pre_reset");
      chk("pre_reset_se", int'(se), 1);
      rst_n = 1'b0;
      en    = 1'b0;
      #1;
      chk("midrst_se", int'(se), 0);
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_at_speed", int'(at_speed), 0);
      chk("midrst_cur_per", int'(cur_per), 0);
      idle_cycles(2);
      rst_n = 1'b1;
      idle_cycles(1000);
      chk("post_rst_busy", int'(busy), 0);
      chk("post_rst_cur_per", int'(cur_per), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
